// File: rtl/opb_status_bank_pkg.sv
// opb_status_bank_pkg: shared types and constants for the OPB status bank.
// The optional timestamp feature is OPB_STATUS_BANK_TSTAMP_EN; it has no
// effect on anything in this package.
package opb_status_bank_pkg;

  // Ack sequencer states of the OPB slave front end
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } opb_state_t;

  // CTRL register bit positions
  localparam int unsigned CTRL_SNAP_BIT   = 0;
  localparam int unsigned CTRL_FREEZE_BIT = 1;
  localparam int unsigned CTRL_COUNT_LSB  = 8;
  localparam int unsigned CTRL_COUNT_W    = 8;

  // Word offsets of the control and timestamp registers
  function automatic int unsigned CTRL_OFS(int unsigned n_ch);
    return n_ch;
  endfunction

  function automatic int unsigned TSTAMP_OFS(int unsigned n_ch);
    return n_ch + 1;
  endfunction

endpackage

// File: rtl/opb_status_bank_if.sv
// opb_status_bank_if: OPB slave-side bus bundle. Bus vectors keep the OPB
// big-endian bit numbering (bit 0 = MSB). Optional feature macro
// OPB_STATUS_BANK_TSTAMP_EN does not change this interface.
interface opb_status_bank_if #(
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32
);
  logic [0:C_OPB_AWIDTH-1]   OPB_ABus;
  logic [0:C_OPB_DWIDTH/8-1] OPB_BE;
  logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
  logic                      OPB_RNW;
  logic                      OPB_select;
  logic                      OPB_seqAddr;
  logic [0:C_OPB_DWIDTH-1]   Sl_DBus;
  logic                      Sl_xferAck;
  logic                      Sl_errAck;
  logic                      Sl_retry;
  logic                      Sl_toutSup;

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_status_bank_opb_slave_if.sv
// opb_slave_if: OPB address decode, 3-state ack sequencer and read-data
// return for the status bank. Presents a registered one-cycle wr_stb/rd_stb
// plus word index, byte enables and write data to the register bank.
// Optional feature macro OPB_STATUS_BANK_TSTAMP_EN is not used here.
module opb_slave_if
  import opb_status_bank_pkg::*;
#(
  parameter int unsigned             C_OPB_AWIDTH = 32,
  parameter int unsigned             C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_4100,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_41FF,
  parameter int unsigned             IDX_W        = C_OPB_AWIDTH - 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  opb_status_bank_if.slave          bus,
  input  logic [C_OPB_DWIDTH-1:0]   rd_data,
  output logic                      wr_stb,
  output logic                      rd_stb,
  output logic [IDX_W-1:0]          word_idx,
  output logic [C_OPB_DWIDTH/8-1:0] be,
  output logic [C_OPB_DWIDTH-1:0]   wdata
);

  opb_state_t                state;
  logic                      xfer_ack;
  logic [C_OPB_DWIDTH-1:0]   dbus_q;
  logic [C_OPB_AWIDTH-1:0]   addr;
  logic [C_OPB_AWIDTH-1:0]   offset;
  logic                      in_range;
  logic                      unused_bits;

  // Bus vectors are [0:N]; plain assignment maps bus bit 0 onto register MSB
  assign addr     = bus.OPB_ABus;
  assign offset   = addr - C_BASEADDR;
  assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  assign bus.Sl_DBus    = dbus_q;
  assign bus.Sl_xferAck = xfer_ack;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

  assign unused_bits = &{1'b0, bus.OPB_seqAddr, offset[1:0]};

  // Ack sequencer: capture in IDLE, ack + commit leaving ACK, one dead cycle in HOLD.
  // Sl_xferAck/Sl_DBus are registered, so they are visible during HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      xfer_ack <= 1'b0;
      dbus_q   <= '0;
      wr_stb   <= 1'b0;
      rd_stb   <= 1'b0;
      word_idx <= '0;
      be       <= '0;
      wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          xfer_ack <= 1'b0;
          dbus_q   <= '0;
          if (bus.OPB_select && in_range) begin
            word_idx <= offset[C_OPB_AWIDTH-1:2];
            be       <= bus.OPB_BE;
            wdata    <= bus.OPB_DBus;
            rd_stb   <= bus.OPB_RNW;
            wr_stb   <= !bus.OPB_RNW;
            state    <= ACK;
          end
        end
        ACK: begin
          xfer_ack <= 1'b1;
          dbus_q   <= rd_stb ? rd_data : '0;
          rd_stb   <= 1'b0;
          wr_stb   <= 1'b0;
          state    <= HOLD;
        end
        HOLD: begin
          xfer_ack <= 1'b0;
          dbus_q   <= '0;
          state    <= IDLE;
        end
        default: begin
          xfer_ack <= 1'b0;
          dbus_q   <= '0;
          rd_stb   <= 1'b0;
          wr_stb   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_status_bank.sv
// opb_status_bank: N_CH user status words exposed over OPB with per-bit
// sticky accumulation (W1C), coherent snapshots, freeze and a snapshot
// counter. Optional feature macro: OPB_STATUS_BANK_TSTAMP_EN adds a
// free-running 32-bit timestamp captured on every accepted snapshot.
module opb_status_bank
  import opb_status_bank_pkg::*;
#(
  parameter logic [31:0]       C_BASEADDR    = 32'h0100_4100,
  parameter logic [31:0]       C_HIGHADDR    = 32'h0100_41FF,
  parameter int unsigned       C_OPB_AWIDTH  = 32,
  parameter int unsigned       C_OPB_DWIDTH  = 32,
  parameter int unsigned       N_CH          = 4,
  parameter int unsigned       DATA_W        = 32,
  parameter logic [DATA_W-1:0] C_STICKY_MASK = 32'h0000_0000
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst_n,
  opb_status_bank_if.slave         opb,
  input  logic [N_CH*DATA_W-1:0]   user_data_in,
  input  logic                     user_snap,
  output logic                     snap_busy_o
);

  localparam int unsigned      IDX_W    = C_OPB_AWIDTH - 2;
  localparam int unsigned      N_LANE   = DATA_W / 8;
  localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(CTRL_OFS(N_CH));

  logic              wr_stb;
  logic              rd_stb;
  logic [IDX_W-1:0]  word_idx;
  logic [N_LANE-1:0] be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] be_mask;

  logic [DATA_W-1:0] live [N_CH];
  logic [DATA_W-1:0] snap [N_CH];
  logic [DATA_W-1:0] clr  [N_CH];
  logic              freeze;
  logic [7:0]        snap_count;
  logic              ctrl_wr;
  logic              sw_snap;
  logic              snap_take;

  opb_slave_if #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_OPB_DWIDTH (C_OPB_DWIDTH),
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .IDX_W        (IDX_W)
  ) u_slave (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .bus      (opb),
    .rd_data  (rd_data),
    .wr_stb   (wr_stb),
    .rd_stb   (rd_stb),
    .word_idx (word_idx),
    .be       (be),
    .wdata    (wdata)
  );

  assign ctrl_wr     = wr_stb && (word_idx == CTRL_IDX);
  assign sw_snap     = ctrl_wr && be[0] && wdata[CTRL_SNAP_BIT];
  assign snap_take   = (user_snap || sw_snap) && !freeze;
  assign snap_busy_o = freeze;

  // Expand byte enables into a per-bit write mask
  always_comb begin
    be_mask = '0;
    for (int unsigned k = 0; k < N_LANE; k++) begin
      be_mask[k*8 +: 8] = {8{be[k]}};
    end
  end

  // Per-channel W1C clear mask, restricted to sticky bits and enabled bytes
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      clr[i] = '0;
      if (wr_stb && (word_idx == IDX_W'(i))) begin
        clr[i] = wdata & be_mask & C_STICKY_MASK;
      end
    end
  end

  // Live accumulation, snapshot capture, snapshot counter and freeze bit
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        live[i] <= '0;
        snap[i] <= '0;
      end
      snap_count <= '0;
      freeze     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        // New data ORs in after the clear, so a same-cycle set beats W1C
        live[i] <= (live[i] & C_STICKY_MASK & ~clr[i]) | user_data_in[i*DATA_W +: DATA_W];
        if (snap_take) begin
          snap[i] <= live[i];
        end
      end
      if (snap_take) begin
        snap_count <= snap_count + 8'd1;
      end
      if (ctrl_wr && be[0]) begin
        freeze <= wdata[CTRL_FREEZE_BIT];
      end
    end
  end

`ifdef OPB_STATUS_BANK_TSTAMP_EN
  localparam logic [IDX_W-1:0] TSTAMP_IDX = IDX_W'(TSTAMP_OFS(N_CH));

  logic [31:0] tstamp_cnt;
  logic [31:0] tstamp;

  // Free-running timestamp, latched on every accepted snapshot
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      tstamp_cnt <= '0;
      tstamp     <= '0;
    end else begin
      tstamp_cnt <= tstamp_cnt + 32'd1;
      if (snap_take) begin
        tstamp <= tstamp_cnt;
      end
    end
  end
`endif

  // Read mux: snapshot words, CTRL, optional TSTAMP, everything else zero
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (word_idx == IDX_W'(i)) begin
        rd_data = snap[i];
      end
    end
    if (word_idx == CTRL_IDX) begin
      rd_data = '0;
      rd_data[CTRL_FREEZE_BIT] = freeze;
      rd_data[CTRL_COUNT_LSB +: CTRL_COUNT_W] = snap_count;
    end
`ifdef OPB_STATUS_BANK_TSTAMP_EN
    if (word_idx == TSTAMP_IDX) begin
      rd_data = tstamp;
    end
`endif
  end

endmodule

// File: tb/tb_opb_status_bank.sv
// tb_opb_status_bank: directed self-checking bench for opb_status_bank.
// Build with OPB_STATUS_BANK_TSTAMP_EN defined to exercise the timestamp.
module tb_opb_status_bank;

  localparam logic [31:0] BASE   = 32'h0100_4100;
  localparam logic [31:0] HIGH   = 32'h0100_41FF;
  localparam logic [31:0] A_CTRL = BASE + 32'd16;
  localparam logic [31:0] A_TS   = BASE + 32'd20;

  logic         clk;
  logic         rst_n;
  logic [127:0] user_data_in;
  logic         user_snap;
  logic         snap_busy_o;
  logic [31:0]  cyc;

  int n_tests;
  int n_fail;
  int exp_count;

  opb_status_bank_if bus ();

  opb_status_bank #(
    .C_BASEADDR    (BASE),
    .C_HIGHADDR    (HIGH),
    .N_CH          (4),
    .DATA_W        (32),
    .C_STICKY_MASK (32'h0000_0001)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .opb          (bus),
    .user_data_in (user_data_in),
    .user_snap    (user_snap),
    .snap_busy_o  (snap_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: cleared by reset, +1 per rising edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  task automatic opb_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
    @(negedge clk);
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_BE     = 4'hF;
    bus.OPB_select = 1'b1;
    lat  = -1;
    data = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.Sl_xferAck === 1'b1) begin
        data = bus.Sl_DBus;
        lat  = n;
        break;
      end
    end
    bus.OPB_select = 1'b0;
    bus.OPB_RNW    = 1'b0;
  endtask

  task automatic opb_write(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output int lat);
    @(negedge clk);
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_BE     = be;
    bus.OPB_DBus   = wd;
    bus.OPB_select = 1'b1;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.Sl_xferAck === 1'b1) begin
        lat = n;
        break;
      end
    end
    bus.OPB_select = 1'b0;
    bus.OPB_DBus   = '0;
  endtask

  task automatic pulse_snap();
    @(negedge clk);
    user_snap = 1'b1;
    @(negedge clk);
    user_snap = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] v);
    user_data_in[ch*32 +: 32] = v;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0 || snap_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b dbus=%h busy=%b required 0/00000000/0",
               bus.Sl_xferAck, bus.Sl_DBus, snap_busy_o);
    end
    rst_n = 1'b1;
    opb_read(A_CTRL, d, lat);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL reset_ack_latency: got %0d required 2", lat);
    end
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h required 00000000", d);
    end
    @(negedge clk);
    n_tests++;
    if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin
      n_fail++;
      $display("FAIL ack_single_pulse: ack=%b dbus=%h required 0/00000000", bus.Sl_xferAck, bus.Sl_DBus);
    end
    for (int i = 0; i < 4; i++) begin
      opb_read(BASE + 32'(4*i), d, lat);
      n_tests++;
      if (lat !== 2 || d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_snap%0d: got %h lat %0d required 00000000 lat 2", i, d, lat);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    int lat;
    set_ch(2, 32'hA5A5_0001);
    pulse_snap();
    exp_count++;
    opb_read(BASE + 32'd8, d, lat);
    n_tests++;
    if (d !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL snap2_capture: got %h required a5a50001", d);
    end
    opb_read(A_CTRL, d, lat);
    n_tests++;
    if (d !== {16'h0, 8'(exp_count), 8'h00}) begin
      n_fail++;
      $display("FAIL snap_count_1: got %h required %h", d, {16'h0, 8'(exp_count), 8'h00});
    end
  endtask

  task automatic test_sticky();
    logic [31:0] d;
    int lat;
    // one-cycle pulse on the sticky bit
    @(negedge clk);
    set_ch(0, 32'h1);
    @(negedge clk);
    set_ch(0, 32'h0);
    // W1C while the bit is re-asserted on the commit edge: set must win
    set_ch(0, 32'h1);
    opb_write(BASE, 32'h1, 4'hF, lat);
    set_ch(0, 32'h0);
    pulse_snap();
    exp_count++;
    opb_read(BASE, d, lat);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL sticky_set_wins: got %h required 00000001", d);
    end
    // clear attempt with the low byte lane disabled must not clear
    opb_write(BASE, 32'h1, 4'b1110, lat);
    pulse_snap();
    exp_count++;
    opb_read(BASE, d, lat);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL sticky_be_gated: got %h required 00000001", d);
    end
    // real clear with no re-assert
    opb_write(BASE, 32'h1, 4'hF, lat);
    pulse_snap();
    exp_count++;
    opb_read(BASE, d, lat);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL sticky_cleared: got %h required 00000000", d);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] d;
    int lat;
    opb_write(A_CTRL, 32'h2, 4'hF, lat);
    n_tests++;
    if (snap_busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_busy: got %b required 1", snap_busy_o);
    end
    set_ch(1, 32'h1234_5678);
    repeat (3) pulse_snap();
    set_ch(1, 32'h1234_5670);
    opb_read(BASE + 32'd4, d, lat);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL freeze_snap_held: got %h required 00000000", d);
    end
    opb_read(A_CTRL, d, lat);
    n_tests++;
    if (d !== {16'h0, 8'(exp_count), 8'h02}) begin
      n_fail++;
      $display("FAIL freeze_ctrl: got %h required %h", d, {16'h0, 8'(exp_count), 8'h02});
    end
    opb_write(A_CTRL, 32'h0, 4'hF, lat);
    opb_write(A_CTRL, 32'h1, 4'hF, lat);
    exp_count++;
    opb_read(BASE + 32'd4, d, lat);
    n_tests++;
    if (d !== 32'h1234_5670) begin
      n_fail++;
      $display("FAIL sw_snap_capture: got %h required 12345670", d);
    end
    opb_read(A_CTRL, d, lat);
    n_tests++;
    if (d !== {16'h0, 8'(exp_count), 8'h00}) begin
      n_fail++;
      $display("FAIL sw_snap_count: got %h required %h", d, {16'h0, 8'(exp_count), 8'h00});
    end
  endtask

  task automatic test_address_range();
    logic [31:0] d;
    logic [31:0] bad [2];
    int lat;
    int bad_cyc;
    bad[0] = HIGH + 32'd4;
    bad[1] = BASE - 32'd4;
    for (int a = 0; a < 2; a++) begin
      @(negedge clk);
      bus.OPB_ABus   = bad[a];
      bus.OPB_RNW    = 1'b1;
      bus.OPB_select = 1'b1;
      bad_cyc = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) bad_cyc++;
      end
      bus.OPB_select = 1'b0;
      n_tests++;
      if (bad_cyc != 0) begin
        n_fail++;
        $display("FAIL out_of_range_%0d: %0d cycles with ack/data, required 0", a, bad_cyc);
      end
    end
    // top word of the window is decoded but unmapped
    opb_read(HIGH - 32'd3, d, lat);
    n_tests++;
    if (lat !== 2 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL high_word: got %h lat %0d required 00000000 lat 2", d, lat);
    end
    opb_write(BASE + 32'd24, 32'hFFFF_FFFF, 4'hF, lat);
    opb_read(BASE + 32'd24, d, lat);
    n_tests++;
    if (lat !== 2 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_word: got %h lat %0d required 00000000 lat 2", d, lat);
    end
  endtask

  task automatic test_tstamp();
    logic [31:0] d;
    logic [31:0] exp_ts;
    int lat;
    for (int k = 0; k < 2000 && cyc < 32'd100; k++) @(negedge clk);
    @(negedge clk);
    user_snap = 1'b1;
    exp_ts = cyc;
    @(negedge clk);
    user_snap = 1'b0;
    exp_count++;
`ifndef OPB_STATUS_BANK_TSTAMP_EN
    exp_ts = 32'h0;
`endif
    opb_read(A_TS, d, lat);
    n_tests++;
    if (lat !== 2 || d !== exp_ts) begin
      n_fail++;
      $display("FAIL tstamp: got %h lat %0d required %h lat 2", d, lat, exp_ts);
    end
  endtask

  task automatic test_count_wrap();
    logic [31:0] d;
    int lat;
    int n;
    n = 256 - exp_count;
    repeat (n) pulse_snap();
    exp_count = 0;
    opb_read(A_CTRL, d, lat);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL count_wrap: got %h required 00000000", d);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    int lat;
    @(negedge clk);
    bus.OPB_ABus   = A_CTRL;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_BE     = 4'hF;
    bus.OPB_DBus   = 32'h2;
    bus.OPB_select = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ack=%b dbus=%h required 0/00000000", bus.Sl_xferAck, bus.Sl_DBus);
    end
    bus.OPB_select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    opb_read(A_CTRL, d, lat);
    n_tests++;
    if (lat !== 2 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_no_write: got %h lat %0d required 00000000 lat 2", d, lat);
    end
    n_tests++;
    if (snap_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_busy: got %b required 0", snap_busy_o);
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    exp_count      = 0;
    rst_n          = 1'b0;
    user_data_in   = '0;
    user_snap      = 1'b0;
    bus.OPB_ABus   = '0;
    bus.OPB_BE     = '0;
    bus.OPB_DBus   = '0;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_select = 1'b0;
    bus.OPB_seqAddr = 1'b0;
    test_reset();
    test_snapshot();
    test_tstamp();
    test_sticky();
    test_freeze();
    test_address_range();
    test_count_wrap();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/opb_status_bank.md
Name: opb_status_bank

Overview:
- Multi-channel successor to the single-word simulink2ppc status register.
- Presents N_CH user status words to the PPC over the OPB slave bus, all in a single OPB_Clk domain.
- Adds per-bit sticky accumulation with write-1-to-clear, coherent all-channel snapshots (hardware strobe or software request), freeze, and a snapshot counter.
- Instantiated once per DSP subsystem in place of N separate status registers.

Parameters:
- C_BASEADDR, 32'h01004100, OPB base address.
- C_HIGHADDR, 32'h010041FF, OPB high address (inclusive).
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width; DATA_W must equal it.
- N_CH, 4, channel count, 1..32.
- DATA_W, 32, bits per channel.
- C_STICKY_MASK, 32'h0000_0000, bits set here are sticky (OR-accumulate) in every channel; the other bits are live.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_in  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- user_snap  in  1  single-cycle snapshot strobe.
- snap_busy_o  out  1  high while freeze=1.

Behaviour:
- Clock and reset: one clock, OPB_Clk; reset OPB_Rst_n is asynchronous, active-low.
- Reset values: all live, snap, ctrl and counter registers = 0; Sl_DBus = 0; Sl_xferAck = 0; FSM = IDLE.
- Live register, per channel, every cycle:
  - live <= (live & STICKY & ~clr) | (data & STICKY) | (data & ~STICKY).
  - Set wins over a same-cycle W1C clear.
- Snapshot event:
  - snap_ev = user_snap | sw_snap (sw_snap is a 1-cycle pulse from the CTRL write).
  - If freeze=0: every snap[i] <= live[i] on the same edge (pre-clear, pre-update value).
  - snap_count (8 bit) increments and wraps 255->0.
  - If freeze=1: the event is dropped and the counter is unchanged.
- Register map (word offset from C_BASEADDR):
  - 0..N_CH-1, SNAP[i]: read returns snap[i]. A write is W1C on the live sticky bits of channel i, gated per byte by BE; non-sticky bits are ignored.
  - N_CH, CTRL: bit0 SNAP (write 1 -> sw_snap pulse, reads 0); bit1 FREEZE (R/W); bits15:8 snap_count (RO); rest 0.
  - N_CH+1, TSTAMP: present only with the optional feature; otherwise reads 0.
  - Remaining in-range offsets read 0 and ignore writes.
- OPB FSM:
  - IDLE -> ACK when OPB_select=1 and C_BASEADDR <= ABus <= C_HIGHADDR. The address, RNW, BE and data are registered.
  - ACK: Sl_xferAck=1 for exactly one cycle. Sl_DBus carries the read data, which is 0 for writes. The write side effect commits on this edge. -> HOLD.
  - HOLD: ack=0, Sl_DBus=0. -> IDLE.
  - Latency: ack 2 cycles after select is sampled. Minimum 3 cycles between acks; no double ack on a lingering select.
- Boundary rules:
  - Out-of-range address: no response; the FSM stays IDLE.
  - Sl_DBus = 0 whenever ack=0, so the bus can be OR-combined.
  - Bus bit 0 = MSB, i.e. register bit 31.
  - Reset asserted mid-transfer: the FSM returns to IDLE immediately with ack=0 and no partial write.

Optional Feature:
- Macro: OPB_STATUS_BANK_TSTAMP_EN.
- Defined:
  - 32-bit free-running counter, reset 0, wraps.
  - Captured into TSTAMP on every accepted snap_ev.
  - Readable at offset N_CH+1.
- Undefined: no counter logic; offset N_CH+1 reads 0.

Decomposition:
- Package opb_status_bank_pkg:
  - FSM state typedef {IDLE, ACK, HOLD}.
  - Offset constants CTRL_OFS(N_CH) and TSTAMP_OFS(N_CH).
  - CTRL bit positions.
- Sub-module opb_slave_if:
  - Owns the address decode, the 3-state ack FSM and read-data muxing.
  - Outputs a registered wr_stb/rd_stb, word index and BE.

Test Plan:
- Reset, then read CTRL and SNAP0-3 -> all 0; Sl_xferAck pulses once, 2 cycles after select.
- user_data_in ch2 = 0xA5A5_0001, user_snap pulse, read SNAP2 -> 0xA5A5_0001; snap_count = 1.
- C_STICKY_MASK = 0x1; pulse ch0 bit0 once, then write 0x1 to SNAP0 while bit0 is re-asserted the same cycle -> live bit stays 1. Clear without re-assert, then snap -> SNAP0 bit0 = 0.
- FREEZE=1, toggle data and pulse user_snap 3x -> SNAP unchanged, count unchanged. FREEZE=0, write CTRL SNAP=1 -> new data captured, count +1.
- Address C_HIGHADDR+4 with select held 5 cycles -> no ack, Sl_DBus = 0. 256 snaps -> snap_count wraps to 0.
- With OPB_STATUS_BANK_TSTAMP_EN: snap at cycle 100, then read TSTAMP -> value of the free-running counter on the snap edge. Without the macro: reads 0.
